// File: rtl/rom_8x8_if.sv
// Read port bundle for the 8x8 constant table.
// The consumer drives addr/en; the ROM returns data_out/valid.
interface rom_8x8_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) ();
    logic [ADDR_W-1:0] addr;
    logic              en;
    logic [DATA_W-1:0] data_out;
    logic              valid;

    modport master (
        output addr,
        output en,
        input  data_out,
        input  valid
    );

    modport slave (
        input  addr,
        input  en,
        output data_out,
        output valid
    );
endinterface

// File: rtl/rom_8x8.sv
// 8-word x 8-bit constant table with a registered read port.
// data_out/valid update one clock after an enabled address sample.
module rom_8x8 #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    rom_8x8_if.slave    bus
);
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    // Fixed table contents; every address code has an entry.
    always_comb begin
        w_word = '0;
        unique case (bus.addr)
            ADDR_W'(0): w_word = DATA_W'(8'h0A);
            ADDR_W'(1): w_word = DATA_W'(8'h1B);
            ADDR_W'(2): w_word = DATA_W'(8'h2C);
            ADDR_W'(3): w_word = DATA_W'(8'h3D);
            ADDR_W'(4): w_word = DATA_W'(8'h4E);
            ADDR_W'(5): w_word = DATA_W'(8'h5F);
            ADDR_W'(6): w_word = DATA_W'(8'h60);
            ADDR_W'(7): w_word = DATA_W'(8'h71);
            default:    w_word = '0;
        endcase
    end

    // Capture the word on enabled edges; valid pulses for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.en;
            if (bus.en) begin
                r_data <= w_word;
            end
        end
    end

    assign bus.data_out = r_data;
    assign bus.valid    = r_valid;
endmodule

// File: tb/tb_rom_8x8.sv
// Self-checking bench for rom_8x8: directed vector table,
// hand-written async-reset / mid-cycle sequences, random run.
module tb_rom_8x8;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [7:0] m_data;

    rom_8x8_if #(.ADDR_W(3), .DATA_W(8)) bus ();

    rom_8x8 #(.ADDR_W(3), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] addr;
        logic [7:0] exp_data;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [15];

    // High nibble is the address, low nibble is (0xA + address) mod 16.
    function automatic logic [7:0] model(input logic [2:0] a);
        int hi;
        int lo;
        hi = int'(a);
        lo = (10 + int'(a)) % 16;
        return 8'((hi * 16) + lo);
    endfunction

    task automatic check8(input string nm, input logic [7:0] act,
                          input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic [2:0] a);
        @(negedge clk);
        bus.en   = e;
        bus.addr = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] held;
        logic       e;
        logic [2:0] a;
        n_checks = 0;
        n_errors = 0;

        vecs[0]  = '{1'b1, 3'd0, 8'h0A, 1'b1};
        vecs[1]  = '{1'b1, 3'd1, 8'h1B, 1'b1};
        vecs[2]  = '{1'b1, 3'd2, 8'h2C, 1'b1};
        vecs[3]  = '{1'b1, 3'd3, 8'h3D, 1'b1};
        vecs[4]  = '{1'b1, 3'd4, 8'h4E, 1'b1};
        vecs[5]  = '{1'b1, 3'd5, 8'h5F, 1'b1};
        vecs[6]  = '{1'b1, 3'd6, 8'h60, 1'b1};
        vecs[7]  = '{1'b1, 3'd7, 8'h71, 1'b1};
        vecs[8]  = '{1'b1, 3'd3, 8'h3D, 1'b1};
        vecs[9]  = '{1'b0, 3'd6, 8'h3D, 1'b0};
        vecs[10] = '{1'b0, 3'd6, 8'h3D, 1'b0};
        vecs[11] = '{1'b0, 3'd6, 8'h3D, 1'b0};
        vecs[12] = '{1'b1, 3'd6, 8'h60, 1'b1};
        vecs[13] = '{1'b1, 3'd7, 8'h71, 1'b1};
        vecs[14] = '{1'b1, 3'd0, 8'h0A, 1'b1};

        // Reset held low with an active read request.
        rst_n    = 1'b0;
        bus.en   = 1'b1;
        bus.addr = 3'd5;
        #1;
        check8("reset_data_t0", bus.data_out, 8'h00);
        check1("reset_valid_t0", bus.valid, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check8("reset_data_hold", bus.data_out, 8'h00);
            check1("reset_valid_hold", bus.valid, 1'b0);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        bus.en = 1'b0;
        #1;
        check8("post_reset_data", bus.data_out, 8'h00);

        // Directed vector table: sweep, enable-low hold, wrap.
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].en, vecs[i].addr);
            check8($sformatf("vec%0d_data", i), bus.data_out,
                   vecs[i].exp_data);
            check1($sformatf("vec%0d_valid", i), bus.valid,
                   vecs[i].exp_valid);
        end

        // Address wiggles between edges; only the edge value counts.
        @(negedge clk);
        held     = bus.data_out;
        bus.en   = 1'b1;
        bus.addr = 3'd1;
        #1;
        bus.addr = 3'd4;
        #1;
        check8("midcyc_no_comb", bus.data_out, held);
        bus.addr = 3'd2;
        #1;
        check8("midcyc_no_comb2", bus.data_out, held);
        @(posedge clk);
        #1;
        check8("midcyc_data", bus.data_out, 8'h2C);
        check1("midcyc_valid", bus.valid, 1'b1);

        // Asynchronous reset in the middle of a cycle.
        step(1'b1, 3'd5);
        check8("pre_areset_data", bus.data_out, 8'h5F);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check8("areset_data", bus.data_out, 8'h00);
        check1("areset_valid", bus.valid, 1'b0);
        @(posedge clk);
        #1;
        check8("areset_hold", bus.data_out, 8'h00);
        @(negedge clk);
        rst_n  = 1'b1;
        bus.en = 1'b0;

        // Random run against the arithmetic model.
        m_data = 8'h00;
        for (int i = 0; i < 200; i++) begin
            e = 1'($urandom_range(0, 1));
            a = 3'($urandom_range(0, 7));
            step(e, a);
            if (e) m_data = model(a);
            check8("rand_data", bus.data_out, m_data);
            check1("rand_valid", bus.valid, e);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rom_8x8.md
Name: rom_8x8

Overview:
- Read-only lookup table: 8 words x 8 bits, fixed contents, synchronous registered read.
- Used as a small constant table (coefficients, patterns) beside datapath logic. Consumers present an address with an enable and take the word one clock later.
- Contents are fixed at elaboration; there is no write path.

Parameters:
- ADDR_W, 3, address width; depth = 2**ADDR_W = 8 words.
- DATA_W, 8, word width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  ADDR_W  read address, sampled on rising clk when en=1.
- data_out  output  DATA_W  registered read data.
- en  input  1  read enable, active-high.
- valid  output  1  high for the cycle after an enabled read; marks data_out as freshly loaded.

Behaviour:
- Contents, address -> word: 0 -> 0x0A, 1 -> 0x1B, 2 -> 0x2C, 3 -> 0x3D, 4 -> 0x4E, 5 -> 0x5F, 6 -> 0x60, 7 -> 0x71.
- Implement the contents as a combinational case/lookup constant.
- Reset:
  - When rst_n=0, data_out=0x00 and valid=0 immediately, independent of clk.
  - Both outputs hold these values while rst_n stays low.
  - The first read can occur on the first rising clk edge at which rst_n=1.
- Read:
  - On a rising clk with rst_n=1 and en=1: data_out <= ROM[addr] and valid <= 1.
  - Latency is 1 clock from the sampling edge to new data.
- Idle:
  - On a rising clk with en=0: data_out holds its previous value and valid <= 0.
- Address changes:
  - Changes between edges have no effect on data_out. There is no combinational path from addr or en to any output.
  - Only the value present at the rising edge matters.
- Back-to-back reads:
  - en held high with a new address every cycle produces one new word per cycle, with no bubbles.
- Wrap-around:
  - The address is exactly ADDR_W bits, so all 8 codes are valid. There are no out-of-range cases and no error output.
- Reset mid-operation:
  - An asserted rst_n overrides any read in progress.
  - A read sampled on the same edge at which rst_n deasserts is not performed. The first read is on the next edge.
- Unknown inputs: no X-propagation requirement, but outputs must be 0-valued after reset regardless of addr/en.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with en=1, addr=5 -> data_out=0x00, valid=0 throughout. Assert rst_n low mid-cycle after data_out=0x5F -> data_out=0x00 without waiting for a clk edge.
- Sequential sweep: en=1, addr 0..7, one address per cycle -> data_out one cycle later = 0x0A, 0x1B, 0x2C, 0x3D, 0x4E, 0x5F, 0x60, 0x71, with valid=1 each cycle.
- Enable low:
  - Read addr=3 (data_out=0x3D), then set en=0 and change addr to 6 for 3 cycles -> data_out stays 0x3D, valid=0.
  - Then en=1 -> data_out becomes 0x60 on the next edge.
- Mid-cycle address change: with en=1, move addr 1 -> 4 -> 2 between two edges, with 2 stable at the edge -> data_out=0x2C. No intermediate value may appear on data_out.
- Wrap: read addr=7 then addr=0 on consecutive cycles -> 0x71 then 0x0A.
- Random: 200 cycles of random en/addr checked against the 8-entry model and 1-cycle latency, with valid equal to the previous cycle's en.
